// File: rtl/mesi_plru_set_engine_if.sv
// Request/response bundle between the trace decoder and the LLC set engine.
// The master drives requests and the snoop reply for its own misses; the slave answers with one response per request.
interface mesi_plru_set_engine_if #(
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 4,
  parameter int WAYS        = 16
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int WAY_BITS = $clog2(WAYS);

  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [ADDR_BITS-1:0] req_addr;
  logic [1:0]           snoop_in;

  logic                 rsp_valid;
  logic                 rsp_hit;
  logic [WAY_BITS-1:0]  rsp_way;
  logic                 rsp_bus_valid;
  logic [1:0]           rsp_bus_op;
  logic [1:0]           rsp_snoop_result;
  logic                 rsp_wb;
  logic [TAG_BITS-1:0]  rsp_wb_tag;
  logic [1:0]           rsp_new_state;

  modport master (
    output req_valid, req_op, req_addr, snoop_in,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_bus_valid, rsp_bus_op,
           rsp_snoop_result, rsp_wb, rsp_wb_tag, rsp_new_state
  );

  modport slave (
    input  req_valid, req_op, req_addr, snoop_in,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_bus_valid, rsp_bus_op,
           rsp_snoop_result, rsp_wb, rsp_wb_tag, rsp_new_state
  );
endinterface

// File: rtl/mesi_plru_set_engine.sv
// Set-associative LLC lookup/replacement engine: tags, MESI states and tree-PLRU bits in flops.
// One request at a time through IDLE -> LOOKUP -> UPDATE, with a registered one-cycle response.
module mesi_plru_set_engine #(
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 4,
  parameter int WAYS        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mesi_plru_set_engine_if.slave bus
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int WAY_BITS = $clog2(WAYS);
  localparam int SETS     = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} fsm_t;
  typedef enum logic [2:0] {
    OP_CPU_RD, OP_CPU_WR, OP_SN_RD, OP_SN_WR, OP_SN_INV, OP_SN_RWIM, OP_CLEAR, OP_NOP
  } op_t;

  localparam logic [1:0] ST_M = 2'd0, ST_E = 2'd1, ST_S = 2'd2, ST_I = 2'd3;
  localparam logic [1:0] BUS_READ = 2'd0, BUS_INV = 2'd2, BUS_RWIM = 2'd3;
  localparam logic [1:0] SN_NOHIT = 2'd0, SN_HIT = 2'd1, SN_HITM = 2'd2;

  fsm_t                  fsm;
  op_t                   op_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic                  hit_q;
  logic [WAY_BITS-1:0]   hway_q;
  logic [WAY_BITS-1:0]   vway_q;

  logic [TAG_BITS-1:0]   tag_mem  [SETS][WAYS];
  logic [1:0]            st_mem   [SETS][WAYS];
  logic [WAYS-2:0]       plru_mem [SETS];

  // Walk from the root: a 0 bit steers left (child 2n+1), a 1 bit steers right (child 2n+2).
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [WAYS-2:0] bits);
    int node;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) node = 2 * node + 1 + int'(bits[node]);
    return WAY_BITS'(node - (WAYS - 1));
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_BITS-1:0] way);
    logic [WAYS-2:0] nb;
    logic            d;
    int              node;
    nb   = bits;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      d        = way[WAY_BITS-1-l];
      nb[node] = ~d;
      node     = 2 * node + 1 + int'(d);
    end
    return nb;
  endfunction

  logic                lk_hit, lk_free;
  logic [WAY_BITS-1:0] lk_hway, lk_vway;

  // Scanning downwards lets the lowest matching / lowest invalid way win.
  always_comb begin
    lk_hit  = 1'b0;
    lk_free = 1'b0;
    lk_hway = '0;
    lk_vway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (st_mem[idx_q][w] != ST_I && tag_mem[idx_q][w] == tag_q) begin
        lk_hit  = 1'b1;
        lk_hway = WAY_BITS'(w);
      end
      if (st_mem[idx_q][w] == ST_I) begin
        lk_free = 1'b1;
        lk_vway = WAY_BITS'(w);
      end
    end
    if (!lk_free) lk_vway = plru_victim(plru_mem[idx_q]);
  end

  logic                u_hit, u_bus, u_wb, u_st_we, u_fill, u_touch, u_cpu;
  logic [WAY_BITS-1:0] u_way;
  logic [1:0]          u_cur, u_new, u_bus_op, u_snp;
  logic [TAG_BITS-1:0] u_wb_tag;

  always_comb begin
    u_cpu = (op_q == OP_CPU_RD) || (op_q == OP_CPU_WR);
    if (op_q == OP_CLEAR || op_q == OP_NOP) u_way = '0;
    else if (hit_q)                         u_way = hway_q;
    else if (u_cpu)                         u_way = vway_q;
    else                                    u_way = '0;
    u_cur    = st_mem[idx_q][u_way];
    u_hit    = hit_q;
    u_new    = ST_M;
    u_bus    = 1'b0;
    u_bus_op = BUS_READ;
    u_snp    = SN_NOHIT;
    u_wb     = 1'b0;
    u_wb_tag = '0;
    u_st_we  = 1'b0;
    u_fill   = 1'b0;
    u_touch  = 1'b0;
    case (op_q)
      OP_CPU_RD, OP_CPU_WR: begin
        u_touch = 1'b1;
        u_st_we = 1'b1;
        if (hit_q) begin
          u_new = (op_q == OP_CPU_RD) ? u_cur : ST_M;
          if (op_q == OP_CPU_WR && u_cur == ST_S) begin
            u_bus    = 1'b1;
            u_bus_op = BUS_INV;
          end
        end else begin
          u_fill   = 1'b1;
          u_bus    = 1'b1;
          u_bus_op = (op_q == OP_CPU_RD) ? BUS_READ : BUS_RWIM;
          u_new    = (op_q == OP_CPU_WR) ? ST_M : ((bus.snoop_in == SN_NOHIT) ? ST_E : ST_S);
          u_wb     = (u_cur == ST_M);
          u_wb_tag = (u_cur == ST_M) ? tag_mem[idx_q][u_way] : '0;
        end
      end
      OP_CLEAR, OP_NOP: u_hit = 1'b0;
      default: begin
        u_new = ST_I;
        if (hit_q) begin
          u_st_we = 1'b1;
          u_new   = u_cur;
          u_snp   = SN_HIT;
          case (op_q)
            OP_SN_RD: u_new = ST_S;
            OP_SN_INV, OP_SN_RWIM: u_new = ST_I;
            default: u_new = u_cur;
          endcase
          // Only reads and RWIMs pull dirty data out of a modified line.
          if ((op_q == OP_SN_RD || op_q == OP_SN_RWIM) && u_cur == ST_M) begin
            u_snp    = SN_HITM;
            u_wb     = 1'b1;
            u_wb_tag = tag_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm                  <= IDLE;
      op_q                 <= OP_NOP;
      tag_q                <= '0;
      idx_q                <= '0;
      hit_q                <= 1'b0;
      hway_q               <= '0;
      vway_q               <= '0;
      bus.req_ready        <= 1'b0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_hit          <= 1'b0;
      bus.rsp_way          <= '0;
      bus.rsp_bus_valid    <= 1'b0;
      bus.rsp_bus_op       <= '0;
      bus.rsp_snoop_result <= '0;
      bus.rsp_wb           <= 1'b0;
      bus.rsp_wb_tag       <= '0;
      bus.rsp_new_state    <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w] <= '0;
          st_mem[s][w]  <= ST_I;
        end
      end
    end else begin
      bus.rsp_valid        <= 1'b0;
      bus.rsp_hit          <= 1'b0;
      bus.rsp_way          <= '0;
      bus.rsp_bus_valid    <= 1'b0;
      bus.rsp_bus_op       <= '0;
      bus.rsp_snoop_result <= '0;
      bus.rsp_wb           <= 1'b0;
      bus.rsp_wb_tag       <= '0;
      bus.rsp_new_state    <= '0;
      case (fsm)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            op_q          <= op_t'(bus.req_op);
            tag_q         <= bus.req_addr[ADDR_BITS-1 -: TAG_BITS];
            idx_q         <= bus.req_addr[OFFSET_BITS +: INDEX_BITS];
            fsm           <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q  <= lk_hit;
          hway_q <= lk_hway;
          vway_q <= lk_vway;
          fsm    <= UPDATE;
        end
        UPDATE: begin
          bus.rsp_valid        <= 1'b1;
          bus.rsp_hit          <= u_hit;
          bus.rsp_way          <= u_way;
          bus.rsp_bus_valid    <= u_bus;
          bus.rsp_bus_op       <= u_bus_op;
          bus.rsp_snoop_result <= u_snp;
          bus.rsp_wb           <= u_wb;
          bus.rsp_wb_tag       <= u_wb_tag;
          bus.rsp_new_state    <= u_new;
          if (u_st_we) st_mem[idx_q][u_way] <= u_new;
          if (u_fill)  tag_mem[idx_q][u_way] <= tag_q;
          if (u_touch) plru_mem[idx_q] <= plru_touch(plru_mem[idx_q], u_way);
          if (op_q == OP_CLEAR) begin
            for (int s = 0; s < SETS; s++) begin
              plru_mem[s] <= '0;
              for (int w = 0; w < WAYS; w++) st_mem[s][w] <= ST_I;
            end
          end
          bus.req_ready <= 1'b1;
          fsm           <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesi_plru_set_engine.sv
// Randomised and directed bench for mesi_plru_set_engine against a set-level MESI/PLRU model.
module tb_mesi_plru_set_engine;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 6;
  localparam int INDEX_BITS  = 4;
  localparam int WAYS        = 16;
  localparam int LOGW        = 4;
  localparam int SETS        = 16;
  localparam int M = 0, E = 1, S = 2, I = 3;

  typedef struct {
    int hit; int way; int busv; int busop; int snp; int wb; int wbtag; int st;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  int mstate [SETS][WAYS];
  int mtag   [SETS][WAYS];
  int mtree  [SETS][WAYS-1];

  always #5 clk = ~clk;

  mesi_plru_set_engine_if #(.ADDR_BITS(ADDR_BITS), .OFFSET_BITS(OFFSET_BITS),
                            .INDEX_BITS(INDEX_BITS), .WAYS(WAYS)) bus ();

  mesi_plru_set_engine #(.ADDR_BITS(ADDR_BITS), .OFFSET_BITS(OFFSET_BITS),
                         .INDEX_BITS(INDEX_BITS), .WAYS(WAYS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] addrOf(input int set, input int tag);
    return (32'(tag) << 10) | (32'(set) << 6);
  endfunction

  task automatic modelReset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        mstate[s][w] = I;
        mtag[s][w]   = 0;
      end
      for (int n = 0; n < WAYS - 1; n++) mtree[s][n] = 0;
    end
  endtask

  // Heap-numbered tree: the level-l node above way w is (2^l - 1) + (w >> (LOGW - l)).
  task automatic modelTouch(input int set, input int way);
    for (int l = 0; l < LOGW; l++)
      mtree[set][(1 << l) - 1 + (way >> (LOGW - l))] = ((way >> (LOGW - 1 - l)) & 1) ? 0 : 1;
  endtask

  function automatic int modelVictim(input int set);
    int p;
    for (int w = 0; w < WAYS; w++) if (mstate[set][w] == I) return w;
    p = 0;
    for (int l = 0; l < LOGW; l++) p = p * 2 + mtree[set][(1 << l) - 1 + p];
    return p;
  endfunction

  task automatic modelApply(input int op, input int set, input int tag, input int snp, output exp_t e);
    int hw, v;
    e = '{default: 0};
    if (op == 6) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) mstate[s][w] = I;
        for (int n = 0; n < WAYS - 1; n++) mtree[s][n] = 0;
      end
      return;
    end
    if (op == 7) return;
    hw = -1;
    for (int w = 0; w < WAYS; w++)
      if (mstate[set][w] != I && mtag[set][w] == tag) begin hw = w; break; end
    e.hit = (hw >= 0) ? 1 : 0;
    if (op <= 1) begin
      if (hw >= 0) begin
        e.way = hw;
        if (op == 1) begin
          if (mstate[set][hw] == S) begin e.busv = 1; e.busop = 2; end
          mstate[set][hw] = M;
        end
        e.st = mstate[set][hw];
      end else begin
        v = modelVictim(set);
        e.way = v;
        if (mstate[set][v] == M) begin e.wb = 1; e.wbtag = mtag[set][v]; end
        e.busv  = 1;
        e.busop = (op == 0) ? 0 : 3;
        mtag[set][v]   = tag;
        mstate[set][v] = (op == 1) ? M : ((snp == 0) ? E : S);
        e.st = mstate[set][v];
      end
      modelTouch(set, e.way);
    end else if (hw < 0) begin
      e.st = I;
    end else begin
      e.way = hw;
      e.snp = 1;
      if ((op == 2 || op == 5) && mstate[set][hw] == M) begin
        e.snp = 2; e.wb = 1; e.wbtag = tag;
      end
      if (op == 2) mstate[set][hw] = S;
      if (op == 4 || op == 5) mstate[set][hw] = I;
      e.st = mstate[set][hw];
    end
  endtask

  // Issues one request at a negedge and returns at the negedge where the response is visible.
  task automatic applyStimulus(input int op, input logic [31:0] addr, input int snp);
    exp_t e;
    int   n;
    modelApply(op, int'(addr[9:6]), int'(addr[31:10]), snp, e);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin checkOutput("ready_timeout", 0, 1); return; end
    bus.req_valid = 1'b1;
    bus.req_op    = 3'(op);
    bus.req_addr  = addr;
    bus.snoop_in  = 2'(snp);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 10) begin @(negedge clk); n++; end
    checkOutput("latency", n, 3);
    if (!bus.rsp_valid) return;
    checkOutput("rsp_hit",       int'(bus.rsp_hit),          e.hit);
    checkOutput("rsp_way",       int'(bus.rsp_way),          e.way);
    checkOutput("rsp_bus_valid", int'(bus.rsp_bus_valid),    e.busv);
    checkOutput("rsp_bus_op",    int'(bus.rsp_bus_op),       e.busop);
    checkOutput("rsp_snoop",     int'(bus.rsp_snoop_result), e.snp);
    checkOutput("rsp_wb",        int'(bus.rsp_wb),           e.wb);
    checkOutput("rsp_wb_tag",    int'(bus.rsp_wb_tag),       e.wbtag);
    checkOutput("rsp_new_state", int'(bus.rsp_new_state),    e.st);
    checkOutput("ready_at_rsp",  int'(bus.req_ready),        1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, rdy, rv, op, set, tag;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.snoop_in  = '0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_ready",     int'(bus.req_ready),     0);
    checkOutput("reset_rsp_valid", int'(bus.rsp_valid),     0);
    checkOutput("reset_new_state", int'(bus.rsp_new_state), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] fill and re-read a line");
    applyStimulus(0, 32'h0000_1040, 0);
    checkOutput("t1_miss", int'(bus.rsp_hit), 0);
    checkOutput("t1_way0", int'(bus.rsp_way), 0);
    checkOutput("t1_read", int'(bus.rsp_bus_op), 0);
    checkOutput("t1_E",    int'(bus.rsp_new_state), E);
    applyStimulus(0, 32'h0000_1040, 0);
    checkOutput("t1_hit",   int'(bus.rsp_hit), 1);
    checkOutput("t1_nobus", int'(bus.rsp_bus_valid), 0);

    $display("[TB] shared fill then upgrade");
    applyStimulus(0, addrOf(1, 'h55), 1);
    checkOutput("t2_S", int'(bus.rsp_new_state), S);
    applyStimulus(1, addrOf(1, 'h55), 0);
    checkOutput("t2_hit", int'(bus.rsp_hit), 1);
    checkOutput("t2_inv", int'(bus.rsp_bus_op), 2);
    checkOutput("t2_M",   int'(bus.rsp_new_state), M);

    $display("[TB] fill a whole set and evict");
    for (int i = 0; i < WAYS; i++) begin
      applyStimulus(1, addrOf(2, 'h100 + i), 0);
      checkOutput("t3_fill_way", int'(bus.rsp_way), i);
    end
    applyStimulus(1, addrOf(2, 'h200), 0);
    checkOutput("t3_victim", int'(bus.rsp_way), 0);
    checkOutput("t3_wb",     int'(bus.rsp_wb), 1);
    checkOutput("t3_wb_tag", int'(bus.rsp_wb_tag), 'h100);
    checkOutput("t3_rwim",   int'(bus.rsp_bus_op), 3);

    $display("[TB] snoops");
    applyStimulus(2, addrOf(2, 'h101), 0);
    checkOutput("t4_hitm", int'(bus.rsp_snoop_result), 2);
    checkOutput("t4_wb",   int'(bus.rsp_wb), 1);
    checkOutput("t4_S",    int'(bus.rsp_new_state), S);
    applyStimulus(5, addrOf(2, 'h101), 0);
    checkOutput("t4_rwim_hit", int'(bus.rsp_snoop_result), 1);
    checkOutput("t4_I",        int'(bus.rsp_new_state), I);
    applyStimulus(2, addrOf(2, 'h300), 0);
    checkOutput("t4_nohit", int'(bus.rsp_snoop_result), 0);
    checkOutput("t4_no_wb", int'(bus.rsp_wb), 0);

    $display("[TB] back-to-back requests with valid held");
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd7;
    rdy = 0;
    rv  = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.req_ready) rdy++;
      if (i > 0 && bus.rsp_valid) rv++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    checkOutput("t5_accepts", rdy, 4);
    checkOutput("t5_rsps",    rv,  3);
    repeat (4) @(negedge clk);

    $display("[TB] reset during update, then clear");
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd1;
    bus.req_addr  = addrOf(5, 9);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rv  = 0;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid) rv++; end
    checkOutput("t6_no_rsp", rv, 0);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    applyStimulus(0, addrOf(5, 9), 0);
    checkOutput("t6_rst_miss", int'(bus.rsp_hit), 0);
    applyStimulus(1, addrOf(3, 7), 0);
    applyStimulus(0, addrOf(3, 8), 0);
    applyStimulus(6, 32'h0, 0);
    applyStimulus(0, addrOf(3, 7), 0);
    checkOutput("t6_clear_miss", int'(bus.rsp_hit), 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 7);
      if (op == 6 && $urandom_range(0, 3) != 0) op = 0;
      set = $urandom_range(0, 3);
      tag = $urandom_range(0, 23);
      applyStimulus(op, addrOf(set, tag) | 32'($urandom_range(0, 63)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
